extinguisher_sequencer: RTL and testbench

EXTINGUISHER_SEQUENCER -- requirements
Module: extinguisher_sequencer

---
 rtl/extinguisher_sequencer_pkg.sv | 23 ++
 rtl/extinguisher_sequencer_cycle_timer.sv | 29 ++
 rtl/extinguisher_sequencer.sv | 132 +++++++++++++
 tb/tb_extinguisher_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/extinguisher_sequencer_pkg.sv
// Shared state encoding and default timing for the extinguisher sequencer,
// the alarm FSM and the LED decoder.
package extinguisher_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DISCH = 3'd2,
    ST_LOCK  = 3'd3,
    ST_ABORT = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_PREALARM_CYC  = 8;
  localparam int unsigned DEF_DISCHARGE_CYC = 16;
  localparam int unsigned DEF_LOCKOUT_CYC   = 32;
  localparam int unsigned DEF_CNT_W         = 8;

  // States in which the sequencer itself demands the siren.
  function automatic logic siren_state(input seq_state_e s);
    return (s == ST_PRE) || (s == ST_DISCH);
  endfunction

endpackage

// File: rtl/extinguisher_sequencer_cycle_timer.sv
// Loadable down-counter shared by every timed state; holds at zero.
module cycle_timer
  import extinguisher_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/extinguisher_sequencer.sv
// Extinguisher discharge sequencer: pre-alarm, valve discharge with
// electrical-fault pause, lockout and manual abort, all outputs registered.
module extinguisher_sequencer
  import extinguisher_sequencer_pkg::*;
#(
  parameter int unsigned PREALARM_CYC  = DEF_PREALARM_CYC,
  parameter int unsigned DISCHARGE_CYC = DEF_DISCHARGE_CYC,
  parameter int unsigned LOCKOUT_CYC   = DEF_LOCKOUT_CYC,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ext_req,
  input  logic [1:0] boc_req,
  input  logic       int_fe,
  input  logic       abort,
  input  logic       apagsis,
  output logic       valve_open,
  output logic       siren_on,
  output logic       siren_fast,
  output logic       busy,
  output logic       done_pulse,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PREALARM_CYC - 1);
  localparam logic [CNT_W-1:0] DISCH_LOAD = CNT_W'(DISCHARGE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYC - 1);

  seq_state_e       state_q;
  seq_state_e       state_nxt;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_zero;

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .en      (tmr_en),
    .zero    (tmr_zero)
  );

  // Next-state and timer control; apagsis is tested first in every state.
  always_comb begin
    state_nxt    = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ext_req && !apagsis && !abort) begin
          state_nxt    = ST_PRE;
          tmr_load     = 1'b1;
          tmr_load_val = PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (apagsis) begin
          state_nxt = ST_IDLE;
        end else if (abort) begin
          state_nxt = ST_ABORT;
        end else if (!ext_req) begin
          state_nxt = ST_IDLE;
        end else if (tmr_zero) begin
          state_nxt    = ST_DISCH;
          tmr_load     = 1'b1;
          tmr_load_val = DISCH_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DISCH: begin
        // An electrical fault freezes the discharge in place; abort has no say here.
        if (apagsis) begin
          state_nxt = ST_IDLE;
        end else if (!int_fe) begin
          if (tmr_zero) begin
            state_nxt    = ST_LOCK;
            tmr_load     = 1'b1;
            tmr_load_val = LOCK_LOAD;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        if (apagsis || tmr_zero) begin
          state_nxt = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_ABORT: begin
        if (apagsis) begin
          state_nxt = ST_IDLE;
        end else if (!abort) begin
          state_nxt    = ST_LOCK;
          tmr_load     = 1'b1;
          tmr_load_val = LOCK_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and outputs share one register stage, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      valve_open <= 1'b0;
      siren_on   <= 1'b0;
      siren_fast <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      valve_open <= (state_nxt == ST_DISCH) && !int_fe;
      siren_on   <= ((|boc_req) || siren_state(state_nxt)) && !apagsis;
      siren_fast <= (boc_req[1] || (state_nxt == ST_DISCH)) && !apagsis;
      busy       <= (state_nxt != ST_IDLE);
      done_pulse <= (state_q == ST_DISCH) && (state_nxt == ST_LOCK);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_extinguisher_sequencer.sv
// Directed scoreboard bench for extinguisher_sequencer at default timing.
module tb_extinguisher_sequencer;
  import extinguisher_sequencer_pkg::*;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       ext_req = 1'b0;
  logic [1:0] boc_req = 2'b00;
  logic       int_fe  = 1'b0;
  logic       abort   = 1'b0;
  logic       apagsis = 1'b0;
  logic       valve_open, siren_on, siren_fast, busy, done_pulse;
  logic [2:0] state_o;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       v;
    logic       son;
    logic       sf;
    logic       b;
    logic       d;
    string      nm;
  } exp_t;

  exp_t sb[$];

  extinguisher_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .ext_req   (ext_req),
    .boc_req   (boc_req),
    .int_fe    (int_fe),
    .abort     (abort),
    .apagsis   (apagsis),
    .valve_open(valve_open),
    .siren_on  (siren_on),
    .siren_fast(siren_fast),
    .busy      (busy),
    .done_pulse(done_pulse),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] st, input logic v, input logic son,
                      input logic sf, input logic b, input logic d, input string nm);
    exp_t e;
    e.cyc = c; e.st = st; e.v = v; e.son = son; e.sf = sf; e.b = b; e.d = d; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic er, input logic [1:0] boc, input logic fe, input logic ab,
                      input logic ap, input logic [2:0] st, input logic v, input logic son,
                      input logic sf, input logic b, input logic d, input string nm);
    @(posedge clk); #1;
    ext_req = er; boc_req = boc; int_fe = fe; abort = ab; apagsis = ap;
    push(cyc + 1, st, v, son, sf, b, d, nm);
  endtask

  // Stimulus with no siren requests and no system-off: siren/busy follow the state.
  task automatic seq(input logic er, input logic fe, input logic ab, input logic [2:0] st,
                     input logic v, input logic d, input string nm);
    step(er, 2'b00, fe, ab, 1'b0, st, v, (st == ST_PRE) || (st == ST_DISCH),
         st == ST_DISCH, st != ST_IDLE, d, nm);
  endtask

  // Monitor: compare every scheduled expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s: check for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if ({state_o, valve_open, siren_on, siren_fast, busy, done_pulse} !==
          {e.st, e.v, e.son, e.sf, e.b, e.d}) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got st=%0d valve=%b son=%b fast=%b busy=%b done=%b, want st=%0d valve=%b son=%b fast=%b busy=%b done=%b",
                 e.nm, cyc, state_o, valve_open, siren_on, siren_fast, busy, done_pulse,
                 e.st, e.v, e.son, e.sf, e.b, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [2:0] st;
    logic       v;
    logic       d;

    // Reset holds everything at zero even with requests present.
    step(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, ST_IDLE, 0, 0, 0, 0, 0, "reset_hold");
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, 0, 0, 0, "reset_hold2");
    @(posedge clk); #1;
    reset = 1'b0; ext_req = 0; boc_req = 0; int_fe = 0; abort = 0; apagsis = 0;
    push(cyc + 1, ST_IDLE, 0, 0, 0, 0, 0, "reset_release");

    // Siren requests and IDLE entry guards.
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 1, 0, 0, 0, "boc1_slow");
    step(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 1, 1, 0, 0, "boc2_fast");
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, ST_IDLE, 0, 0, 0, 0, 0, "apagsis_idle");
    step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, ST_IDLE, 0, 0, 0, 0, 0, "abort_idle");
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, 0, 0, 0, "idle_quiet");

    // One-cycle request: one PRE cycle, then false alarm back to IDLE.
    seq(1'b1, 1'b0, 1'b0, ST_PRE, 0, 0, "pulse_pre");
    seq(1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, "pulse_idle");
    seq(1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, "pulse_idle2");

    // Held request: PRE 1..8, DISCH 9..24, LOCK 25..56, IDLE 57, PRE again 58.
    for (int s = 0; s <= 58; s++) begin
      n  = s + 1;
      st = (n <= 8) ? ST_PRE : (n <= 24) ? ST_DISCH : (n <= 56) ? ST_LOCK :
           (n == 58) ? ST_PRE : ST_IDLE;
      v  = (st == ST_DISCH);
      d  = (n == 25);
      seq(s <= 57, 1'b0, 1'b0, st, v, d, "hold");
    end
    seq(1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, "hold_end");

    // Five-cycle fault pause mid-discharge; abort ignored in DISCH and LOCK.
    for (int s = 0; s <= 62; s++) begin
      n  = s + 1;
      st = (n <= 8) ? ST_PRE : (n <= 29) ? ST_DISCH : (n <= 61) ? ST_LOCK : ST_IDLE;
      v  = (st == ST_DISCH) && !(n >= 13 && n <= 17);
      d  = (n == 30);
      seq(s <= 40, (s >= 12 && s <= 16), (s == 20 || s == 35 || s == 36), st, v, d, "int_fe");
    end

    // Abort in third PRE cycle held ten cycles: ABORT 4..13, LOCK 14..45.
    for (int s = 0; s <= 46; s++) begin
      n  = s + 1;
      st = (n <= 3) ? ST_PRE : (n <= 13) ? ST_ABORT : (n <= 45) ? ST_LOCK : ST_IDLE;
      seq(s <= 3, 1'b0, (s >= 3 && s <= 12), st, 0, 0, "abort");
    end

    // System-off in fourth DISCH cycle dominates ext_req, abort and boc_req.
    for (int s = 0; s <= 11; s++) begin
      n  = s + 1;
      st = (n <= 8) ? ST_PRE : ST_DISCH;
      seq(1'b1, 1'b0, 1'b0, st, st == ST_DISCH, 0, "apagsis_pre");
    end
    step(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, ST_IDLE, 0, 0, 0, 0, 0, "apagsis_disch");
    for (int s = 0; s < 3; s++) seq(1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, "apagsis_after");

    // Asynchronous reset in the fourth DISCH cycle.
    for (int s = 0; s <= 10; s++) begin
      n  = s + 1;
      st = (n <= 8) ? ST_PRE : ST_DISCH;
      seq(1'b1, 1'b0, 1'b0, st, st == ST_DISCH, 0, "areset_pre");
    end
    @(posedge clk); #1;
    ext_req = 1'b1;
    @(posedge clk); #1;
    ext_req = 1'b0;
    #1 reset = 1'b1;
    push(cyc, ST_IDLE, 0, 0, 0, 0, 0, "areset_async");
    push(cyc + 1, ST_IDLE, 0, 0, 0, 0, 0, "areset_held");
    @(posedge clk); #1;
    reset = 1'b0;
    push(cyc + 1, ST_IDLE, 0, 0, 0, 0, 0, "areset_release");
    for (int s = 0; s < 4; s++) seq(1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0, "areset_no_resume");

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d checks still pending, want 0", sb.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
